// File: rtl/jenc_byte_packer_pkg.sv
// rtl/jenc_byte_packer_pkg.sv - shared constants and types for the JPEG byte packer
//
// Purpose: bus width constants, byte-count type and the input byte-count clamp.
// Optional feature macro used by the top: JENC_BYTE_PACKER_BYTECOUNT_EN.

package jenc_byte_packer_pkg;

   localparam int IN_BYTES  = 8;
   localparam int OUT_BYTES = 4;

   typedef logic [3:0] nbytes_t;

   // Counts 9..15 cannot be produced by a well-behaved upstream; treat them as a full beat.
   function automatic nbytes_t clamp_nbytes(input nbytes_t n);
      return (n > 4'd8) ? 4'd8 : n;
   endfunction

endpackage

// File: rtl/jenc_byte_packer_if.sv
// rtl/jenc_byte_packer_if.sv - valid/hold handshake bundle for the byte packer
//
// Purpose: groups the input beat bus and the output word bus.
// Ports:   in_data/in_nbytes/in_tlast/in_valid -> packer, in_hold <- packer
//          out_data/out_nbytes/out_tlast/out_valid <- packer, out_hold -> packer
// Modports: master = environment (upstream + downstream), slave = packer.

interface jenc_byte_packer_if;

   logic [63:0]                     in_data;
   jenc_byte_packer_pkg::nbytes_t   in_nbytes;
   logic                            in_tlast;
   logic                            in_valid;
   logic                            in_hold;

   logic [31:0]                     out_data;
   logic [2:0]                      out_nbytes;
   logic                            out_tlast;
   logic                            out_valid;
   logic                            out_hold;

   modport master (
      output in_data, in_nbytes, in_tlast, in_valid, out_hold,
      input  in_hold, out_data, out_nbytes, out_tlast, out_valid
   );

   modport slave (
      input  in_data, in_nbytes, in_tlast, in_valid, out_hold,
      output in_hold, out_data, out_nbytes, out_tlast, out_valid
   );

endinterface

// File: rtl/jenc_byte_packer_append.sv
// rtl/jenc_byte_packer_append.sv - combinational insert of up to 8 bytes at a byte offset
//
// Purpose: writes data bytes 0..nbytes-1 into buffer slots offset..offset+nbytes-1.
// Ports:   buf_in  - current buffer, byte 0 in the MSBs
//          offset  - first free slot
//          data    - MSB-aligned input bytes
//          nbytes  - bytes to insert (already clamped, 0 means no change)
//          buf_out - updated buffer

module jenc_byte_packer_append
   import jenc_byte_packer_pkg::*;
#(
   parameter int BUF_BYTES = 16
) (
   input  logic [BUF_BYTES*8-1:0]         buf_in,
   input  logic [$clog2(BUF_BYTES+1)-1:0] offset,
   input  logic [IN_BYTES*8-1:0]          data,
   input  nbytes_t                        nbytes,
   output logic [BUF_BYTES*8-1:0]         buf_out
);

   always_comb begin
      buf_out = buf_in;
      for (int i = 0; i < BUF_BYTES; i++) begin
         for (int k = 0; k < IN_BYTES; k++) begin
            if ((k < int'(nbytes)) && (i == int'(offset) + k)) begin
               buf_out[(BUF_BYTES-1-i)*8 +: 8] = data[(IN_BYTES-1-k)*8 +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/jenc_byte_packer.sv
// rtl/jenc_byte_packer.sv - repacks 0..8-byte stuffed beats into dense 32-bit words
//
// Purpose: byte buffer with fill counter; emits 4-byte words, flushes the final
//          partial word of an image with its byte count and zero padding.
// Ports:   clk, reset (async, active-high)
//          bus      - jenc_byte_packer_if.slave (input beats, output words)
//          out_size - bytes popped in the current image
//                     (only with JENC_BYTE_PACKER_BYTECOUNT_EN defined)

module jenc_byte_packer
   import jenc_byte_packer_pkg::*;
#(
   parameter int BUF_BYTES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   jenc_byte_packer_if.slave     bus
`ifdef JENC_BYTE_PACKER_BYTECOUNT_EN
   ,
   output logic [31:0]           out_size
`endif
);

   localparam int FW = $clog2(BUF_BYTES+1);
   localparam int BW = BUF_BYTES*8;

   logic [BW-1:0] buf_q, buf_pp, buf_next;
   logic [FW-1:0] fill_q, fill_pp, fill_next;
   logic          last_pending_q, last_pending_next;

   logic          out_valid_w, out_tlast_w, in_hold_w;
   logic [2:0]    out_nbytes_w;
   logic          pop, push;
   nbytes_t       nb, append_nb;

   // Everything visible outside is a function of registers only.
   assign out_valid_w  = (fill_q >= FW'(OUT_BYTES)) | last_pending_q;
   assign out_tlast_w  = last_pending_q & (fill_q <= FW'(OUT_BYTES));
   assign out_nbytes_w = !out_valid_w ? 3'd0 : (out_tlast_w ? fill_q[2:0] : 3'd4);
   // Room for a full 8-byte beat is required before accepting anything.
   assign in_hold_w    = last_pending_q | (fill_q > FW'(BUF_BYTES-IN_BYTES));

   assign bus.out_valid  = out_valid_w;
   assign bus.out_tlast  = out_tlast_w;
   assign bus.out_nbytes = out_nbytes_w;
   assign bus.in_hold    = in_hold_w;

   always_comb begin
      bus.out_data = '0;
      for (int k = 0; k < OUT_BYTES; k++) begin
         // Slots past fill hold stale bytes from earlier shifts; blank them on the flush word.
         if (!(out_tlast_w && (k >= int'(fill_q)))) begin
            bus.out_data[(OUT_BYTES-1-k)*8 +: 8] = buf_q[BW-1-8*k -: 8];
         end
      end
   end

   assign pop  = out_valid_w & ~bus.out_hold;
   assign push = bus.in_valid & ~in_hold_w;
   assign nb   = clamp_nbytes(bus.in_nbytes);
   assign append_nb = push ? nb : 4'd0;

   // A tlast pop and a push never coincide: last_pending forces in_hold.
   always_comb begin
      buf_pp            = pop ? (buf_q << (OUT_BYTES*8)) : buf_q;
      fill_pp           = fill_q;
      last_pending_next = last_pending_q;
      if (pop) begin
         if (out_tlast_w) begin
            fill_pp           = '0;
            last_pending_next = 1'b0;
         end else begin
            fill_pp = fill_q - FW'(OUT_BYTES);
         end
      end
      fill_next = push ? (fill_pp + FW'(nb)) : fill_pp;
      if (push && bus.in_tlast) begin
         last_pending_next = 1'b1;
      end
   end

   jenc_byte_packer_append #(
      .BUF_BYTES (BUF_BYTES)
   ) u_append (
      .buf_in  (buf_pp),
      .offset  (fill_pp),
      .data    (bus.in_data),
      .nbytes  (append_nb),
      .buf_out (buf_next)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fill_q         <= '0;
         last_pending_q <= 1'b0;
      end else begin
         fill_q         <= fill_next;
         last_pending_q <= last_pending_next;
      end
   end

   // Buffer contents are meaningless while fill says they are empty, so no reset.
   always_ff @(posedge clk) begin
      buf_q <= buf_next;
   end

`ifdef JENC_BYTE_PACKER_BYTECOUNT_EN
   logic [31:0] size_q;
   logic        image_done_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         size_q       <= '0;
         image_done_q <= 1'b0;
      end else begin
         if (push && image_done_q) begin
            size_q       <= '0;
            image_done_q <= 1'b0;
         end else if (pop) begin
            size_q <= size_q + 32'(out_nbytes_w);
            if (out_tlast_w) begin
               image_done_q <= 1'b1;
            end
         end
      end
   end

   assign out_size = size_q;
`endif

endmodule

// File: tb/tb_jenc_byte_packer.sv
// tb/tb_jenc_byte_packer.sv - self-checking bench for jenc_byte_packer

module tb_jenc_byte_packer;
   import jenc_byte_packer_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   jenc_byte_packer_if bus ();
`ifdef JENC_BYTE_PACKER_BYTECOUNT_EN
   logic [31:0] out_size;
`endif

   jenc_byte_packer #(.BUF_BYTES(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus)
`ifdef JENC_BYTE_PACKER_BYTECOUNT_EN
      ,
      .out_size (out_size)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Reference model: the byte stream in order, plus the cumulative byte index of each image end.
   logic [7:0]  exp_bytes[$];
   int          exp_ends[$];
   int          pushed_total = 0;
   int          popped_total = 0;
   int          words_seen = 0;
   int          tlast_seen = 0;
   logic [31:0] last_data = '0;
   logic [2:0]  last_nb = '0;
   bit          rand_hold = 0;

   // Monitor: checks every consumed word against the model, records every accepted beat.
   initial begin : monitor
      logic [7:0] got, expb;
      int n;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (bus.out_valid && !bus.out_hold) begin
               words_seen++;
               checks++;
               if (!bus.out_tlast && bus.out_nbytes !== 3'd4) begin
                  errors++;
                  $display("FAIL word_nbytes: got %0d expected 4", bus.out_nbytes);
               end else if (bus.out_tlast && bus.out_nbytes > 3'd4) begin
                  errors++;
                  $display("FAIL final_nbytes: got %0d expected <=4", bus.out_nbytes);
               end
               for (int k = 0; k < 4; k++) begin
                  got = bus.out_data[31-8*k -: 8];
                  if (k < int'(bus.out_nbytes)) begin
                     checks++;
                     popped_total++;
                     if (exp_bytes.size() == 0) begin
                        errors++;
                        $display("FAIL word_byte: got %02h expected no byte", got);
                     end else begin
                        expb = exp_bytes.pop_front();
                        if (got !== expb) begin
                           errors++;
                           $display("FAIL word_byte: got %02h expected %02h", got, expb);
                        end
                     end
                  end else if (bus.out_tlast) begin
                     checks++;
                     if (got !== 8'h00) begin
                        errors++;
                        $display("FAIL pad_byte: got %02h expected 00", got);
                     end
                  end
               end
               if (bus.out_tlast) begin
                  tlast_seen++;
                  last_data = bus.out_data;
                  last_nb   = bus.out_nbytes;
                  checks++;
                  if (exp_ends.size() == 0 || exp_ends[0] != popped_total) begin
                     errors++;
                     $display("FAIL tlast_position: got %0d expected %0d", popped_total,
                              (exp_ends.size() == 0) ? -1 : exp_ends[0]);
                  end
                  if (exp_ends.size() != 0) void'(exp_ends.pop_front());
               end
            end
            if (bus.in_valid && !bus.in_hold) begin
               n = (bus.in_nbytes > 4'd8) ? 8 : int'(bus.in_nbytes);
               for (int k = 0; k < n; k++) exp_bytes.push_back(bus.in_data[63-8*k -: 8]);
               pushed_total += n;
               if (bus.in_tlast) exp_ends.push_back(pushed_total);
            end
         end
      end
   end

   initial begin : hold_driver
      forever begin
         @(posedge clk);
         #1;
         if (rand_hold) bus.out_hold = ($urandom_range(0, 99) < 40);
      end
   end

   task automatic send_beat(input logic [63:0] d, input int n, input bit t);
      int cyc = 0;
      bit acc = 0;
      bus.in_data   = d;
      bus.in_nbytes = 4'(n);
      bus.in_tlast  = t;
      bus.in_valid  = 1'b1;
      while (!acc && cyc < 500) begin
         @(negedge clk);
         acc = !bus.in_hold;
         @(posedge clk);
         #1;
         cyc++;
      end
      bus.in_valid = 1'b0;
      bus.in_data  = {$urandom, $urandom};
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL beat_accept: got timeout expected acceptance");
      end
   endtask

   task automatic wait_drain();
      int cyc = 0;
      bit done = 0;
      while (!done && cyc < 2000) begin
         @(negedge clk);
         done = (exp_bytes.size() == 0) && (exp_ends.size() == 0) && !bus.out_valid;
         cyc++;
      end
      @(posedge clk);
      #1;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL drain: got %0d bytes pending expected 0", exp_bytes.size());
      end
   endtask

   function automatic logic [63:0] pack_bytes(input int first, input int n);
      logic [63:0] d = '0;
      for (int k = 0; k < n; k++) d[63-8*k -: 8] = 8'(first + k);
      return d;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_nbytes = '0; bus.in_tlast = 1'b0;
      bus.out_hold = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks += 4;
      if (bus.out_valid !== 1'b0)   begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      if (bus.out_tlast !== 1'b0)   begin errors++; $display("FAIL reset_out_tlast: got %b expected 0", bus.out_tlast); end
      if (bus.out_nbytes !== 3'd0)  begin errors++; $display("FAIL reset_out_nbytes: got %0d expected 0", bus.out_nbytes); end
      if (bus.in_hold !== 1'b0)     begin errors++; $display("FAIL reset_in_hold: got %b expected 0", bus.in_hold); end
`ifdef JENC_BYTE_PACKER_BYTECOUNT_EN
      checks++;
      if (out_size !== 32'd0) begin errors++; $display("FAIL reset_out_size: got %0d expected 0", out_size); end
`endif
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_aligned();
      int w0 = words_seen, t0 = tlast_seen;
      send_beat({32'h11223344, 32'h0}, 4, 0);
      send_beat({32'h55667788, 32'h0}, 4, 0);
      send_beat({32'h99AABBCC, 32'h0}, 4, 0);
      send_beat({32'hDDEEFF00, 32'h0}, 4, 1);
      wait_drain();
      checks += 4;
      if (words_seen - w0 != 4) begin errors++; $display("FAIL aligned_words: got %0d expected 4", words_seen - w0); end
      if (tlast_seen - t0 != 1) begin errors++; $display("FAIL aligned_tlast: got %0d expected 1", tlast_seen - t0); end
      if (last_data !== 32'hDDEEFF00) begin errors++; $display("FAIL aligned_last_data: got %08h expected DDEEFF00", last_data); end
      if (last_nb !== 3'd4) begin errors++; $display("FAIL aligned_last_nb: got %0d expected 4", last_nb); end
   endtask

   task automatic test_ragged();
      int w0 = words_seen;
      send_beat(pack_bytes(8'h01, 3), 3, 0);
      send_beat(pack_bytes(8'h04, 5), 5, 0);
      send_beat(pack_bytes(8'h09, 1), 1, 0);
      send_beat(pack_bytes(8'h0A, 8), 8, 1);
      wait_drain();
      checks += 3;
      if (words_seen - w0 != 5) begin errors++; $display("FAIL ragged_words: got %0d expected 5", words_seen - w0); end
      if (last_nb !== 3'd1) begin errors++; $display("FAIL ragged_last_nb: got %0d expected 1", last_nb); end
      if (last_data !== 32'h11000000) begin errors++; $display("FAIL ragged_last_data: got %08h expected 11000000", last_data); end
`ifdef JENC_BYTE_PACKER_BYTECOUNT_EN
      checks++;
      if (out_size !== 32'd17) begin errors++; $display("FAIL size_final: got %0d expected 17", out_size); end
      send_beat(pack_bytes(8'h40, 3), 3, 0);
      checks++;
      if (out_size !== 32'd0) begin errors++; $display("FAIL size_clear: got %0d expected 0", out_size); end
      send_beat({$urandom, $urandom}, 0, 1);
      wait_drain();
      checks++;
      if (out_size !== 32'd3) begin errors++; $display("FAIL size_second: got %0d expected 3", out_size); end
`endif
   endtask

   task automatic test_backpressure();
      int w0 = words_seen;
      bus.out_hold = 1'b1;
      send_beat({$urandom, $urandom}, 8, 0);
      send_beat({$urandom, $urandom}, 8, 0);
      checks += 3;
      if (bus.in_hold !== 1'b1)   begin errors++; $display("FAIL bp_in_hold: got %b expected 1", bus.in_hold); end
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b expected 1", bus.out_valid); end
      if (bus.out_tlast !== 1'b0) begin errors++; $display("FAIL bp_out_tlast: got %b expected 0", bus.out_tlast); end
      repeat (6) @(posedge clk);
      #1;
      checks += 2;
      if (bus.in_hold !== 1'b1) begin errors++; $display("FAIL bp_in_hold_held: got %b expected 1", bus.in_hold); end
      if (words_seen != w0) begin errors++; $display("FAIL bp_no_pop: got %0d expected %0d", words_seen, w0); end
      fork
         begin
            send_beat({$urandom, $urandom}, 8, 0);
            send_beat({$urandom, $urandom}, 8, 1);
         end
         begin
            repeat (2) @(posedge clk);
            #1;
            bus.out_hold = 1'b0;
         end
      join
      wait_drain();
      checks++;
      if (words_seen - w0 != 8) begin errors++; $display("FAIL bp_words: got %0d expected 8", words_seen - w0); end
   endtask

   task automatic test_empty_tlast();
      int w0 = words_seen;
      bus.out_hold = 1'b1;
      send_beat({$urandom, $urandom}, 0, 1);
      repeat (2) @(posedge clk);
      #1;
      checks += 5;
      if (bus.in_hold !== 1'b1)      begin errors++; $display("FAIL empty_in_hold: got %b expected 1", bus.in_hold); end
      if (bus.out_valid !== 1'b1)    begin errors++; $display("FAIL empty_out_valid: got %b expected 1", bus.out_valid); end
      if (bus.out_tlast !== 1'b1)    begin errors++; $display("FAIL empty_out_tlast: got %b expected 1", bus.out_tlast); end
      if (bus.out_nbytes !== 3'd0)   begin errors++; $display("FAIL empty_out_nbytes: got %0d expected 0", bus.out_nbytes); end
      if (bus.out_data !== 32'h0)    begin errors++; $display("FAIL empty_out_data: got %08h expected 00000000", bus.out_data); end
      bus.out_hold = 1'b0;
      wait_drain();
      checks += 2;
      if (words_seen - w0 != 1) begin errors++; $display("FAIL empty_words: got %0d expected 1", words_seen - w0); end
      if (bus.in_hold !== 1'b0) begin errors++; $display("FAIL empty_release: got %b expected 0", bus.in_hold); end
   endtask

   task automatic test_reset_mid();
      int w0;
      bus.out_hold = 1'b1;
      send_beat({$urandom, $urandom}, 3, 0);
      send_beat({$urandom, $urandom}, 4, 0);
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", bus.out_valid); end
      #2;
      reset = 1'b1;
      #1;
      checks += 2;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", bus.out_valid); end
      if (bus.in_hold !== 1'b0)   begin errors++; $display("FAIL mid_reset_hold: got %b expected 0", bus.in_hold); end
      exp_bytes.delete();
      exp_ends.delete();
      pushed_total = 0;
      popped_total = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.out_hold = 1'b0;
      w0 = words_seen;
      send_beat(pack_bytes(8'hA0, 5), 5, 1);
      wait_drain();
      checks += 2;
      if (words_seen - w0 != 2) begin errors++; $display("FAIL mid_words: got %0d expected 2", words_seen - w0); end
      if (last_data !== 32'hA4000000) begin errors++; $display("FAIL mid_last_data: got %08h expected A4000000", last_data); end
   endtask

   task automatic test_random();
      int t0 = tlast_seen;
      int nbeats, n;
      rand_hold = 1;
      for (int img = 0; img < 20; img++) begin
         nbeats = $urandom_range(1, 5);
         for (int b = 0; b < nbeats; b++) begin
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
            send_beat({$urandom, $urandom}, n, b == nbeats - 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
         end
      end
      rand_hold = 0;
      @(posedge clk);
      #1;
      bus.out_hold = 1'b0;
      wait_drain();
      checks++;
      if (tlast_seen - t0 != 20) begin errors++; $display("FAIL random_images: got %0d expected 20", tlast_seen - t0); end
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_ragged();
      test_backpressure();
      test_empty_tlast();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
